// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store engine in front of a single-port word memory, big-endian lanes.
// Latency: loads/SW 2 cycles, SB/SH 3 (read-modify-write), misaligned 1; ls_start ignored while busy.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_start,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_busy,
    output logic        ls_done,
    output logic        ls_misaligned,
    output logic [17:0] mem_adress,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  op_q;
    logic [19:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        mem_write_en;

    // Address bits above the memory window are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ls_addr[31:20];

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
            OP_LW, OP_SW:         is_misaligned = |off;
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'b0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'b0, h};
            default: load_ext = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wd);
        store_merge = word;
        case (op)
            OP_SB: begin
                case (off)
                    2'd0:    store_merge[31:24] = wd[7:0];
                    2'd1:    store_merge[23:16] = wd[7:0];
                    2'd2:    store_merge[15:8]  = wd[7:0];
                    default: store_merge[7:0]   = wd[7:0];
                endcase
            end
            OP_SH: begin
                if (off[1]) store_merge[15:0]  = wd[15:0];
                else        store_merge[31:16] = wd[15:0];
            end
            default: store_merge = wd;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        mem_read     = 1'b0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (ls_start) begin
                    if (is_misaligned(ls_op, ls_addr[1:0])) state_n = DONE;
                    else if (ls_op == OP_SW)                state_n = WRITE;
                    else                                    state_n = READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                state_n  = (op_q == OP_SB || op_q == OP_SH) ? WRITE : DONE;
            end
            WRITE: begin
                mem_write_en = 1'b1;
                state_n      = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            word_q        <= '0;
            ls_rdata      <= '0;
            ls_misaligned <= 1'b0;
        end else begin
            if (state == IDLE && ls_start) begin
                op_q    <= ls_op;
                addr_q  <= ls_addr[19:0];
                wdata_q <= ls_wdata;
            end
            if (state == READ) begin
                word_q <= mem_read_data;
                if (op_q != OP_SB && op_q != OP_SH)
                    ls_rdata <= load_ext(op_q, addr_q[1:0], mem_read_data);
            end
            // Only the IDLE->DONE shortcut is taken by misaligned requests.
            if (state_n == DONE)
                ls_misaligned <= (state == IDLE);
        end
    end

    assign ls_busy        = (state != IDLE);
    assign ls_done        = (state == DONE);
    assign mem_adress     = addr_q[19:2];
    assign mem_write_data = store_merge(op_q, addr_q[1:0], word_q, wdata_q);
    assign mem_write      = mem_write_en & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table-driven accesses against a word-memory model, scoreboard on ls_done.
module tb_load_store_unit;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        reset, ls_start;
    logic [2:0]  ls_op;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        ls_busy, ls_done, ls_misaligned;
    logic [17:0] mem_adress;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign mem_read_data = mem[mem_adress[7:0]];

    load_store_unit dut (
        .clk(clk), .reset(reset), .ls_start(ls_start), .ls_op(ls_op),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .ls_busy(ls_busy), .ls_done(ls_done), .ls_misaligned(ls_misaligned),
        .mem_adress(mem_adress), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk;
        int          idx;
        logic [31:0] mval;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc0;
        int   rd0;
        int   wr0;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[25];
    int n_cmp = 0, n_err = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: memory model writes on the edge, then outputs are sampled and scored.
    task automatic tick();
        logic        we;
        logic [7:0]  wi;
        logic [31:0] wd;
        exp_t        e;
        @(negedge clk);
        we = mem_write; wi = mem_adress[7:0]; wd = mem_write_data;
        @(posedge clk);
        if (we === 1'b1) mem[wi] = wd;
        #1;
        cyc++;
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_read === 1'b1)  rd_cnt++;
            if (mem_write === 1'b1) wr_cnt++;
            if (exp_q.size() > 0)
                check("mem_adress", {14'b0, mem_adress}, {14'b0, exp_q[0].v.addr[19:2]});
        end
        if (ls_done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: ls_done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("ls_rdata", ls_rdata, e.v.rdata);
                check("ls_misaligned", {31'b0, ls_misaligned}, {31'b0, e.v.mis});
                check("latency", cyc - e.cyc0, e.v.lat);
                check("mem_read_pulses", rd_cnt - e.rd0, e.v.nrd);
                check("mem_write_pulses", wr_cnt - e.wr0, e.v.nwr);
                if (e.v.chk) check("mem_word", mem[e.v.idx], e.v.mval);
            end
        end
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        ls_op = v.op; ls_addr = v.addr; ls_wdata = v.wdata; ls_start = 1'b1;
        e.v = v; e.cyc0 = cyc; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 12) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: %0d request(s) without ls_done, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        vec_t v;
        int   d0;
        //          op   addr          wdata         rdata         mis  lat rd wr chk idx mval
        vecs[0]  = '{LB,  32'h4,        32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[1]  = '{LBU, 32'h4,        32'h0,        32'h00000080, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[2]  = '{LH,  32'h6,        32'h0,        32'h000056F0, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[3]  = '{LH,  32'h4,        32'h0,        32'hFFFF8034, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[4]  = '{LW,  32'h4,        32'h0,        32'h803456F0, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[5]  = '{LHU, 32'h4,        32'h0,        32'h00008034, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[6]  = '{SB,  32'h5,        32'h000000AA, 32'h00008034, 1'b0, 3, 1, 1, 1'b1, 1, 32'h80AA56F0};
        vecs[7]  = '{SH,  32'h4,        32'h00001234, 32'h00008034, 1'b0, 3, 1, 1, 1'b1, 1, 32'h123456F0};
        vecs[8]  = '{LW,  32'h2,        32'h0,        32'h00008034, 1'b1, 1, 0, 0, 1'b0, 0, 32'h0};
        vecs[9]  = '{LB,  32'h7,        32'h0,        32'hFFFFFFF0, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[10] = '{SW,  32'h8,        32'hDEADBEEF, 32'hFFFFFFF0, 1'b0, 2, 0, 1, 1'b1, 2, 32'hDEADBEEF};
        vecs[11] = '{LH,  32'h3,        32'h0,        32'hFFFFFFF0, 1'b1, 1, 0, 0, 1'b0, 0, 32'h0};
        vecs[12] = '{LW,  32'h8,        32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[13] = '{SH,  32'h1,        32'h0000FFFF, 32'hDEADBEEF, 1'b1, 1, 0, 0, 1'b1, 0, 32'h11223344};
        vecs[14] = '{SB,  32'hB,        32'h12345655, 32'hDEADBEEF, 1'b0, 3, 1, 1, 1'b1, 2, 32'hDEADBE55};
        vecs[15] = '{LHU, 32'hA,        32'h0,        32'h0000BE55, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[16] = '{SW,  32'h6,        32'h0,        32'h0000BE55, 1'b1, 1, 0, 0, 1'b1, 1, 32'h123456F0};
        vecs[17] = '{SH,  32'h6,        32'hFFFFABCD, 32'h0000BE55, 1'b0, 3, 1, 1, 1'b1, 1, 32'h1234ABCD};
        vecs[18] = '{LH,  32'h6,        32'h0,        32'hFFFFABCD, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[19] = '{LW,  32'hABC00004, 32'h0,        32'h1234ABCD, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[20] = '{LBU, 32'h9,        32'h0,        32'h000000AD, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[21] = '{LB,  32'hA,        32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[22] = '{SB,  32'h8,        32'h0000007F, 32'hFFFFFFBE, 1'b0, 3, 1, 1, 1'b1, 2, 32'h7FADBE55};
        vecs[23] = '{LHU, 32'h8,        32'h0,        32'h00007FAD, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        vecs[24] = '{LW,  32'h0,        32'h0,        32'h11223344, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h803456F0;

        reset = 1'b1; ls_start = 1'b0; ls_op = 3'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (3) tick();
        check("reset_busy", {31'b0, ls_busy}, 32'd0);
        check("reset_done", {31'b0, ls_done}, 32'd0);
        check("reset_rdata", ls_rdata, 32'd0);
        check("reset_misaligned", {31'b0, ls_misaligned}, 32'd0);
        check("reset_mem_read", {31'b0, mem_read}, 32'd0);
        check("reset_mem_write", {31'b0, mem_write}, 32'd0);
        check("reset_mem_adress", {14'b0, mem_adress}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 25; i++) begin
            issue(vecs[i]);
            tick();
            ls_start = 1'b0;
            drain();
            tick();
        end

        // Second start while an LW is in flight is dropped; back-to-back start right after done.
        d0 = done_cnt;
        v = '{LW, 32'h4, 32'h0, 32'h1234ABCD, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        issue(v);
        tick();
        ls_op = LB; ls_addr = 32'h8; ls_start = 1'b1;
        tick();
        ls_start = 1'b0;
        check("inflight_done_count", done_cnt - d0, 32'd1);
        tick();
        check("inflight_idle_after_done", {31'b0, ls_busy}, 32'd0);
        v = '{LBU, 32'h4, 32'h0, 32'h00000012, 1'b0, 2, 1, 0, 1'b0, 0, 32'h0};
        issue(v);
        tick();
        ls_start = 1'b0;
        drain();
        repeat (3) tick();
        check("inflight_total_done", done_cnt - d0, 32'd2);

        // Reset during the WRITE cycle of SW must suppress the write and the done pulse.
        d0 = done_cnt;
        ls_op = SW; ls_addr = 32'h0; ls_wdata = 32'hFFFFFFFF; ls_start = 1'b1;
        tick();
        ls_start = 1'b0;
        check("sw_write_strobe", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("write_gated_by_reset", {31'b0, mem_write}, 32'd0);
        tick();
        reset = 1'b0;
        check("abort_busy", {31'b0, ls_busy}, 32'd0);
        check("abort_rdata", ls_rdata, 32'd0);
        check("abort_word0", mem[0], 32'h11223344);
        repeat (3) tick();
        check("abort_no_done", done_cnt - d0, 32'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; ls_op = LW; ls_addr = 32'h4; ls_start = 1'b1;
        tick();
        reset = 1'b0; ls_start = 1'b0;
        check("reset_priority_busy", {31'b0, ls_busy}, 32'd0);
        tick();
        check("reset_priority_still_idle", {31'b0, ls_busy}, 32'd0);

        v = '{LW, 32'h0, 32'h0, 32'h11223344, 1'b0, 2, 1, 0, 1'b1, 0, 32'h11223344};
        issue(v);
        tick();
        ls_start = 1'b0;
        drain();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: ls_start  input  1  access request; sampled only in IDLE.
REQ-004: ls_op  input  3  access type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-005: ls_addr  input  32  byte address; bits [19:2] form the word address, bits [1:0] form the byte offset.
REQ-006: ls_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
REQ-007: ls_rdata  output  32  load result, extended to 32 bits.
REQ-008: ls_busy  output  1  high whenever state is not IDLE.
REQ-009: ls_done  output  1  one-cycle completion pulse.
REQ-010: ls_misaligned  output  1  error flag, valid while ls_done is high.
REQ-011: mem_adress  output  18  word address to data_memory_block.
REQ-012: mem_write_data  output  32  word to data_memory_block.
REQ-013: mem_read  output  1  read strobe to data_memory_block.
REQ-014: mem_write  output  1  write strobe; memory writes on the rising edge while this is high.
REQ-015: mem_read_data  input  32  combinational read word from data_memory_block.

Function
REQ-016: FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-017: IDLE with ls_start high: latch ls_op, ls_addr and ls_wdata, then branch on the latched request:
- misaligned: go to DONE.
- any load, SB or SH: go to READ.
- SW: go to WRITE.
REQ-018: IDLE with ls_start low: stay in IDLE.
REQ-019: Misaligned is defined as:
- LH, LHU or SH with addr[0] = 1.
- LW or SW with addr[1:0] not equal to 00.
- LB, LBU and SB are never misaligned.
REQ-020: In READ, mem_read = 1, and the memory word SHALL be captured into an internal register at the end of the cycle; next state is DONE for loads and WRITE for SB/SH.
REQ-021: In WRITE, mem_write = 1 and mem_write_data = merged word:
- SW: ls_wdata.
- SB/SH: the captured word with only the addressed byte or halfword replaced.
- Next state is DONE.
REQ-022: In DONE, ls_done = 1 for exactly one cycle; next state is IDLE.
REQ-023: Byte order is big-endian:
- offset 0 maps to word bits [31:24] and offset 3 to bits [7:0].
- halfword offset 0 maps to bits [31:16] and offset 2 to bits [15:0].
REQ-024: Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through unchanged.
REQ-025: ls_rdata SHALL update at the READ-to-DONE edge and hold until the next load completes; stores and misaligned accesses leave it unchanged.
REQ-026: ls_misaligned SHALL be updated on entry to DONE for every access and hold its value until the next request reaches DONE; a misaligned access issues no mem_read and no mem_write.
REQ-027: Latency from the ls_start edge to ls_done:
- 2 cycles for loads and SW.
- 3 cycles for SB/SH.
- 1 cycle for misaligned requests.
REQ-028: ls_start while ls_busy is high SHALL be ignored, with no queuing.
REQ-029: Back-to-back requests are allowed: ls_start accepted in the cycle after ls_done, since the state is IDLE then.
REQ-030: mem_adress SHALL always equal the latched ls_addr[19:2], and mem_read/mem_write SHALL be 0 outside READ/WRITE.
REQ-031: mem_read and mem_write SHALL never be high in the same cycle.

Reset
REQ-032: reset high at a rising edge SHALL force IDLE from any state, with outputs cleared as follows:
- ls_rdata = 0
- ls_done = 0
- ls_busy = 0
- ls_misaligned = 0
- latched request = 0
REQ-033: mem_write SHALL be gated combinationally by reset low, so a WRITE cycle with reset high performs no memory write.
REQ-034: A request aborted by reset SHALL produce no ls_done pulse.
REQ-035: reset has priority over ls_start in the same cycle.

Verification
REQ-036: Preload word 1 = 0x803456F0; LB at addr 4 -> ls_rdata = 0xFFFFFF80, ls_done 2 cycles after start; LBU at addr 4 -> 0x00000080.
REQ-037: LH at addr 6 -> 0x000056F0; LH at addr 4 -> 0xFFFF8034; LW at addr 4 -> 0x803456F0, all with ls_misaligned = 0.
REQ-038: SB at addr 5 with ls_wdata = 0x000000AA -> one mem_write pulse 2 cycles after start, word 1 = 0x80AA56F0, ls_done at 3 cycles; then SH at addr 4 with 0x00001234 -> word 1 = 0x123456F0.
REQ-039: LW at addr 2 -> ls_done with ls_misaligned = 1 one cycle after start, no mem_read/mem_write pulse, ls_rdata unchanged.
REQ-040: Assert reset during the WRITE cycle of SW at addr 0 with data 0xFFFFFFFF -> word 0 unchanged, no ls_done, ls_busy = 0 on the next cycle.
REQ-041: Pulse ls_start during an in-flight LW -> second request ignored, exactly one ls_done; new request accepted in the cycle after ls_done.
